// File: rtl/fifo_rd_arb_if.sv
// Read-side bundle between the per-channel FIFO read ports, the arbiter and the consumer.
// Carries the per-channel empty/data/pop signals and the tagged valid/ready output word.
// master: the arbiter side (drives rinc and the m_* word); slave: the FIFOs plus consumer.
interface fifo_rd_arb_if #(
    parameter int NCH   = 4,
    parameter int DSIZE = 8
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0]       rempty;   // per-channel empty flag, rclk domain
    logic [NCH*DSIZE-1:0] rdata;    // channel i at [i*DSIZE +: DSIZE]
    logic [NCH-1:0]       rinc;     // per-channel pop strobe, one-hot or zero
    logic                 m_valid;  // output word valid
    logic                 m_ready;  // consumer accepts word
    logic [DSIZE-1:0]     m_data;   // output word
    logic [CW-1:0]        m_ch;     // source channel of m_data

    modport master (
        input  rempty, rdata, m_ready,
        output rinc, m_valid, m_data, m_ch
    );

    modport slave (
        output rempty, rdata, m_ready,
        input  rinc, m_valid, m_data, m_ch
    );
endinterface

// File: rtl/fifo_rd_arb.sv
// Round-robin read arbiter: pops up to BURST words per grant from NCH FIFOs into one tagged output register.
// Latency: 2 rclk edges from rempty falling (in IDLE) to m_valid; 1 word/cycle inside a grant, 1 bubble per grant change.
// Backpressure: no pop while the output register is full and m_ready=0; the held word stays stable until accepted.
//
// Ports: rclk, rrst_n (async active-low); bus (fifo_rd_arb_if.master): rempty/rdata in, rinc out,
//        m_valid/m_data/m_ch out, m_ready in.
// Optional build macro: FIFO_RD_ARB_FIXED_PRIO_EN selects lowest-index-first instead of round-robin.
module fifo_rd_arb #(
    parameter int NCH   = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic           rclk,
    input  logic           rrst_n,
    fifo_rd_arb_if.master  bus
);
    localparam int CW = $clog2(NCH);
    localparam int BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] BURST_C = BW'(BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    gnt;
`ifndef FIFO_RD_ARB_FIXED_PRIO_EN
    logic [CW-1:0]    last;     // most recently granted channel; search starts after it
`endif
    logic [BW-1:0]    cnt;
    logic [BW-1:0]    cnt_nxt;
    logic             m_valid_q;
    logic [DSIZE-1:0] m_data_q;
    logic [CW-1:0]    m_ch_q;

    logic             found;
    logic [CW-1:0]    sel;
    logic             gnt_empty;
    logic             space;
    logic             pop;

    // Channel search used in IDLE.
    always_comb begin
        found = 1'b0;
        sel   = '0;
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NCH; k++) begin
            if (!found && !bus.rempty[k]) begin
                found = 1'b1;
                sel   = CW'(k);
            end
        end
`else
        // Offsets 1..NCH so the last granted channel is considered last.
        for (int k = 1; k <= NCH; k++) begin
            if (!found && !bus.rempty[(int'(last) + k) % NCH]) begin
                found = 1'b1;
                sel   = CW'((int'(last) + k) % NCH);
            end
        end
`endif
    end

    assign gnt_empty = bus.rempty[gnt];
    assign space     = ~m_valid_q | bus.m_ready;
    assign pop       = (state == GRANT) && !gnt_empty && space && (cnt < BURST_C);
    assign cnt_nxt   = cnt + BW'(pop);

    // Next state and the combinational pop strobe.
    always_comb begin
        state_nxt = state;
        bus.rinc  = '0;
        if (pop) begin
            bus.rinc[gnt] = 1'b1;
        end
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Leaving on the BURST-th pop edge saves a cycle per full burst.
                if (gnt_empty || (cnt_nxt == BURST_C)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state     <= IDLE;
            gnt       <= '0;
`ifndef FIFO_RD_ARB_FIXED_PRIO_EN
            last      <= CW'(NCH - 1);
`endif
            cnt       <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (found) begin
                    gnt  <= sel;
`ifndef FIFO_RD_ARB_FIXED_PRIO_EN
                    last <= sel;
`endif
                    cnt  <= '0;
                end
            end else begin
                cnt <= cnt_nxt;
            end

            // A pop overwrites the register even when the old word is accepted the same cycle.
            if (pop) begin
                m_data_q  <= bus.rdata[int'(gnt) * DSIZE +: DSIZE];
                m_ch_q    <= gnt;
                m_valid_q <= 1'b1;
            end else if (m_valid_q && bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_ch    = m_ch_q;
endmodule
